// File: rtl/rv32_pkg.sv
// Shared RV32I execute-stage definitions: operation classes, funct3 encodings
// and branch conditions used by the ALU and its register stage.
package rv32_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    KIND_OP     = 2'd0,
    KIND_ADD    = 2'd1,
    KIND_BRANCH = 2'd2
  } alu_kind_e;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  // Encoded as the branch funct3 so the field can be cast directly.
  typedef enum logic [2:0] {
    BR_EQ  = 3'b000,
    BR_NE  = 3'b001,
    BR_LT  = 3'b100,
    BR_GE  = 3'b101,
    BR_LTU = 3'b110,
    BR_GEU = 3'b111
  } br_cond_e;

endpackage

// File: rtl/rv32_alu_comb.sv
// Combinational RV32I ALU core: next result, signed overflow of the add/sub
// actually performed, and branch condition.
module rv32_alu_comb
  import rv32_pkg::*;
(
  input  logic [1:0]      kind,
  input  logic [2:0]      func3,
  input  logic            alt,
  input  logic            a_zero,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] next_result,
  output logic            next_overflow,
  output logic            next_taken
);

  logic [XLEN-1:0] a_eff;
  logic [XLEN-1:0] sum;
  logic [XLEN-1:0] diff;
  logic [XLEN-1:0] sra_res;
  logic [4:0]      shamt;
  logic            ovf_add;
  logic            ovf_sub;
  logic            lt_s;
  logic            lt_u;
  logic            eq;

  always_comb begin
    a_eff   = a_zero ? '0 : a;
    shamt   = b[4:0];
    sum     = a_eff + b;
    diff    = a_eff - b;
    sra_res = $signed(a_eff) >>> shamt;
    ovf_add = (a_eff[XLEN-1] == b[XLEN-1]) && (sum[XLEN-1] != a_eff[XLEN-1]);
    ovf_sub = (a_eff[XLEN-1] != b[XLEN-1]) && (diff[XLEN-1] != a_eff[XLEN-1]);
    // True compares; the sign of diff alone is wrong when the subtraction overflows.
    lt_s    = $signed(a_eff) < $signed(b);
    lt_u    = a_eff < b;
    eq      = a_eff == b;

    next_result   = sum;
    next_overflow = ovf_add;
    next_taken    = 1'b0;

    case (alu_kind_e'(kind))
      KIND_OP: begin
        next_overflow = 1'b0;
        case (func3)
          F3_ADD_SUB: begin
            next_result   = alt ? diff : sum;
            next_overflow = alt ? ovf_sub : ovf_add;
          end
          F3_SLL:     next_result = a_eff << shamt;
          F3_SLT:     next_result = {{(XLEN-1){1'b0}}, lt_s};
          F3_SLTU:    next_result = {{(XLEN-1){1'b0}}, lt_u};
          F3_XOR:     next_result = a_eff ^ b;
          F3_SRL_SRA: next_result = alt ? sra_res : (a_eff >> shamt);
          F3_OR:      next_result = a_eff | b;
          default:    next_result = a_eff & b;
        endcase
      end
      KIND_BRANCH: begin
        next_result   = diff;
        next_overflow = ovf_sub;
        case (br_cond_e'(func3))
          BR_EQ:   next_taken = eq;
          BR_NE:   next_taken = !eq;
          BR_LT:   next_taken = lt_s;
          BR_GE:   next_taken = !lt_s;
          BR_LTU:  next_taken = lt_u;
          BR_GEU:  next_taken = !lt_u;
          default: next_taken = 1'b0;
        endcase
      end
      default: begin
        next_result   = sum;
        next_overflow = ovf_add;
      end
    endcase
  end

endmodule

// File: rtl/rv32_exec_alu.sv
// Registered RV32I execute ALU: combinational core plus one output register
// stage with rst > flush > stall > load priority.
module rv32_exec_alu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic [1:0]      kind,
  input  logic [2:0]      func3,
  input  logic            alt,
  input  logic            a_zero,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            overflow,
  output logic            branch_taken
);

  logic [XLEN-1:0] next_result;
  logic            next_overflow;
  logic            next_taken;

  rv32_alu_comb u_alu_comb (
    .kind          (kind),
    .func3         (func3),
    .alt           (alt),
    .a_zero        (a_zero),
    .a             (a),
    .b             (b),
    .next_result   (next_result),
    .next_overflow (next_overflow),
    .next_taken    (next_taken)
  );

  // A bubble reads as all-zero, including zero itself.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      result       <= '0;
      zero         <= 1'b0;
      overflow     <= 1'b0;
      branch_taken <= 1'b0;
    end else if (!stall) begin
      result       <= next_result;
      zero         <= (next_result == '0);
      overflow     <= next_overflow;
      branch_taken <= next_taken;
    end
  end

endmodule

// File: tb/tb_rv32_exec_alu.sv
// Self-checking bench for rv32_exec_alu: directed vectors plus randomized
// traffic against an arithmetic reference model.
module tb_rv32_exec_alu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  kind = 2'd0;
  logic [2:0]  func3 = 3'd0;
  logic        alt = 1'b0;
  logic        a_zero = 1'b0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic [31:0] result;
  logic        zero;
  logic        overflow;
  logic        branch_taken;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_r = 32'd0;
  logic        exp_z = 1'b0;
  logic        exp_o = 1'b0;
  logic        exp_t = 1'b0;

  always #5 clk = ~clk;

  rv32_exec_alu #(.XLEN(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .flush        (flush),
    .kind         (kind),
    .func3        (func3),
    .alt          (alt),
    .a_zero       (a_zero),
    .a            (a),
    .b            (b),
    .result       (result),
    .zero         (zero),
    .overflow     (overflow),
    .branch_taken (branch_taken)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference: operands as 64-bit integers, overflow means the true sum or
  // difference does not fit in a signed 32-bit value.
  function automatic void model(input logic [1:0] k, input logic [2:0] f3, input logic al,
                                input logic az, input logic [31:0] av, input logic [31:0] bv,
                                output logic [31:0] r, output logic ov, output logic tk);
    logic [31:0] ae;
    longint sa, sb, ua, ub, full, t;
    int sh;
    ae = az ? 32'd0 : av;
    sa = longint'($signed(ae));
    sb = longint'($signed(bv));
    ua = longint'({32'd0, ae});
    ub = longint'({32'd0, bv});
    sh = int'(bv[4:0]);
    r = 32'd0; ov = 1'b0; tk = 1'b0;
    if (k == 2'd0) begin
      case (f3)
        3'd0: begin
          full = al ? (sa - sb) : (sa + sb);
          r = full[31:0];
          ov = (full > 64'sd2147483647) || (full < -64'sd2147483648);
        end
        3'd1: begin t = ua * (longint'(1) << sh); r = t[31:0]; end
        3'd2: r = (sa < sb) ? 32'd1 : 32'd0;
        3'd3: r = (ua < ub) ? 32'd1 : 32'd0;
        3'd4: r = ae ^ bv;
        3'd5: begin t = al ? (sa >>> sh) : (ua / (longint'(1) << sh)); r = t[31:0]; end
        3'd6: r = ae | bv;
        default: r = ae & bv;
      endcase
    end else if (k == 2'd2) begin
      full = sa - sb;
      r = full[31:0];
      ov = (full > 64'sd2147483647) || (full < -64'sd2147483648);
      case (f3)
        3'd0: tk = (ua == ub);
        3'd1: tk = (ua != ub);
        3'd4: tk = (sa < sb);
        3'd5: tk = (sa >= sb);
        3'd6: tk = (ua < ub);
        3'd7: tk = (ua >= ub);
        default: tk = 1'b0;
      endcase
    end else begin
      full = ua + ub;
      t = sa + sb;
      r = full[31:0];
      ov = (t > 64'sd2147483647) || (t < -64'sd2147483648);
    end
  endfunction

  task automatic drive(input logic r_i, input logic fl_i, input logic st_i, input logic [1:0] k,
                       input logic [2:0] f3, input logic al, input logic az,
                       input logic [31:0] av, input logic [31:0] bv);
    logic [31:0] nr;
    logic no, nt;
    @(negedge clk);
    rst = r_i; flush = fl_i; stall = st_i;
    kind = k; func3 = f3; alt = al; a_zero = az; a = av; b = bv;
    model(k, f3, al, az, av, bv, nr, no, nt);
    @(posedge clk);
    #1;
    if (r_i || fl_i) begin
      exp_r = 32'd0; exp_z = 1'b0; exp_o = 1'b0; exp_t = 1'b0;
    end else if (!st_i) begin
      exp_r = nr; exp_z = (nr == 32'd0); exp_o = no; exp_t = nt;
    end
    check("result", result, exp_r);
    check("zero", {31'd0, zero}, {31'd0, exp_z});
    check("overflow", {31'd0, overflow}, {31'd0, exp_o});
    check("branch_taken", {31'd0, branch_taken}, {31'd0, exp_t});
  endtask

  task automatic op(input logic [1:0] k, input logic [2:0] f3, input logic al,
                    input logic az, input logic [31:0] av, input logic [31:0] bv);
    drive(1'b0, 1'b0, 1'b0, k, f3, al, az, av, bv);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h8000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 4));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    for (int i = 0; i < 2; i++)
      drive(1'b1, 1'b0, 1'b0, 2'($urandom), 3'($urandom), 1'($urandom), 1'($urandom),
            $urandom, $urandom);
    check("rst_result", result, 32'd0);

    op(2'd1, 3'd3, 1'b1, 1'b0, 32'd5, 32'd7);
    check("add_5_7", result, 32'd12);

    op(2'd0, 3'd0, 1'b1, 1'b0, 32'h8000_0000, 32'd1);
    check("sub_ovf", {31'd0, overflow}, 32'd1);
    op(2'd0, 3'd0, 1'b1, 1'b0, 32'd3, 32'd3);
    check("sub_zero", {31'd0, zero}, 32'd1);
    op(2'd0, 3'd5, 1'b0, 1'b0, 32'h8000_0000, 32'h21);
    check("srl", result, 32'h4000_0000);
    op(2'd0, 3'd5, 1'b1, 1'b0, 32'h8000_0000, 32'h21);
    check("sra", result, 32'hC000_0000);
    op(2'd0, 3'd1, 1'b0, 1'b0, 32'h0000_0001, 32'hFFFF_FFE4);
    check("sll_mask", result, 32'h0000_0010);
    op(2'd0, 3'd2, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1);
    check("slt", result, 32'd1);
    op(2'd0, 3'd3, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1);
    check("sltu", result, 32'd0);
    op(2'd2, 3'd4, 1'b0, 1'b0, 32'h8000_0000, 32'h7FFF_FFFF);
    check("blt", {31'd0, branch_taken}, 32'd1);
    op(2'd2, 3'd7, 1'b0, 1'b0, 32'h8000_0000, 32'h7FFF_FFFF);
    check("bgeu", {31'd0, branch_taken}, 32'd1);
    op(2'd2, 3'd2, 1'b0, 1'b0, 32'd1, 32'd1);
    check("b010", {31'd0, branch_taken}, 32'd0);

    op(2'd1, 3'd0, 1'b0, 1'b0, 32'h8, 32'h8);
    for (int i = 0; i < 3; i++)
      drive(1'b0, 1'b0, 1'b1, 2'd0, 3'd4, 1'b0, 1'b0, $urandom, $urandom);
    check("stall_hold", result, 32'h10);
    op(2'd2, 3'd0, 1'b0, 1'b0, 32'd9, 32'd9);
    drive(1'b0, 1'b1, 1'b1, 2'd1, 3'd0, 1'b0, 1'b0, 32'd1, 32'd2);
    check("flush_stall", result, 32'd0);

    op(2'd1, 3'd0, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'h1234_5000);
    check("lui", result, 32'h1234_5000);

    for (int i = 0; i < 1500; i++)
      drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) == 0), ($urandom_range(0, 4) == 0),
            2'($urandom), 3'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0),
            pick_operand(), pick_operand());

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
